// File: rtl/kogge_stone_adder16.sv
// kogge_stone_adder16
// Registered 16-bit adder. The carry chain is a 4-level Kogge-Stone
// prefix network of explicit generate/propagate cells (spans 1, 2, 4, 8).
// The carry-in is folded into the bit-0 generate term. The sum and the
// carry-out are captured in output registers, so the latency is one clock.

// Black prefix cell: combines a node's group (g_hi, p_hi) with the
// adjacent lower group (g_lo, p_lo).
module ks_black_cell (
   input  logic g_hi,
   input  logic p_hi,
   input  logic g_lo,
   input  logic p_lo,
   output logic g_out,
   output logic p_out
);

   assign g_out = g_hi | (p_hi & g_lo);
   assign p_out = p_hi & p_lo;

endmodule

module kogge_stone_adder16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] A,
   input  logic [15:0] B,
   input  logic        Cin,
   output logic [15:0] S,
   output logic        Cout
);

   localparam int WIDTH  = 16;
   localparam int LEVELS = 4;

   // Bit-level generate and propagate terms.
   logic [WIDTH-1:0] g_bit;
   logic [WIDTH-1:0] p_bit;

   // Prefix state per level. Level 0 is the bit level with Cin folded in.
   // Level LEVELS holds the complete group generates G[i:-1].
   logic [LEVELS:0][WIDTH-1:0] g_lvl;
   logic [LEVELS:0][WIDTH-1:0] p_lvl;

   // Carries into each bit, plus the carry out of bit 15.
   logic [WIDTH:0] carry;

   logic [WIDTH-1:0] s_next;
   logic             cout_next;
   logic [WIDTH-1:0] s_reg;
   logic             cout_reg;

   // The top-level group propagates are not needed. Once Cin is folded in,
   // every final group generate already spans down to the carry-in.
   logic unused_p_top;
   assign unused_p_top = ^p_lvl[LEVELS];

   assign g_bit = A & B;
   assign p_bit = A ^ B;

   // Level 0: bit 0 absorbs the carry-in as a generate at position -1.
   assign g_lvl[0][0]         = g_bit[0] | (p_bit[0] & Cin);
   assign g_lvl[0][WIDTH-1:1] = g_bit[WIDTH-1:1];
   assign p_lvl[0]            = p_bit;

   // Prefix network. At each level, nodes at or above the span combine with
   // the node one span below them. Lower nodes already hold their complete
   // prefix, so they pass through unchanged.
   generate
      for (genvar lk = 0; lk < LEVELS; lk++) begin : g_level
         localparam int SPAN = 1 << lk;
         for (genvar gi = 0; gi < WIDTH; gi++) begin : g_node
            if (gi >= SPAN) begin : g_cell
               ks_black_cell u_cell (
                  .g_hi  (g_lvl[lk][gi]),
                  .p_hi  (p_lvl[lk][gi]),
                  .g_lo  (g_lvl[lk][gi-SPAN]),
                  .p_lo  (p_lvl[lk][gi-SPAN]),
                  .g_out (g_lvl[lk+1][gi]),
                  .p_out (p_lvl[lk+1][gi])
               );
            end else begin : g_pass
               assign g_lvl[lk+1][gi] = g_lvl[lk][gi];
               assign p_lvl[lk+1][gi] = p_lvl[lk][gi];
            end
         end
      end
   endgenerate

   // Carry into bit i+1 is the group generate of bits i down to -1 (Cin).
   assign carry[0] = Cin;
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_carry
         assign carry[gi+1] = g_lvl[LEVELS][gi];
      end
   endgenerate

   assign s_next    = p_bit ^ carry[WIDTH-1:0];
   assign cout_next = carry[WIDTH];

   // Output registers. Reset clears the result that would otherwise be
   // captured on this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_reg    <= '0;
         cout_reg <= 1'b0;
      end else begin
         s_reg    <= s_next;
         cout_reg <= cout_next;
      end
   end

   assign S    = s_reg;
   assign Cout = cout_reg;

endmodule

// File: tb/tb_kogge_stone_adder16.sv
// tb_kogge_stone_adder16
// Random and directed checking of the registered 16-bit adder against a
// plain-arithmetic reference. Fixed vectors with literal expectations pin
// the reference itself.
`timescale 1ns/1ps

module tb_kogge_stone_adder16;

   logic        clk;
   logic        rst_n;
   logic [15:0] A;
   logic [15:0] B;
   logic        Cin;
   logic [15:0] S;
   logic        Cout;

   int n_cmp;
   int n_bad;

   kogge_stone_adder16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .Cin   (Cin),
      .S     (S),
      .Cout  (Cout)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        cout;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got {Cout,S}=%05h expected %05h", name, act, exp);
      end
   endtask

   // Reference: every edge, the registered result is either 0 (reset)
   // or the zero-extended 17-bit sum of the sampled operands.
   initial begin
      forever begin
         logic [16:0] exp_sum;
         @(posedge clk);
         if (rst_n === 1'b0)
            exp_sum = 17'd0;
         else
            exp_sum = {1'b0, A} + {1'b0, B} + {16'd0, Cin};
         #1;
         check("model", {Cout, S}, exp_sum);
      end
   end

   initial begin
      n_cmp = 0;
      n_bad = 0;

      vecs[0] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[1] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[2] = '{16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0};
      vecs[3] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0};
      vecs[4] = '{16'hCCCC, 16'h3333, 1'b1, 16'h0000, 1'b1};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1};
      vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
      vecs[7] = '{16'h0F0F, 16'h00F0, 1'b0, 16'h0FFF, 1'b0};

      // Reset holds the outputs at zero even with carry-generating inputs.
      rst_n = 1'b0;
      A     = 16'hFFFF;
      B     = 16'h0001;
      Cin   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #2;
         check("reset_hold", {Cout, S}, 17'h00000);
         $display("reset edge %0d: S=%04h Cout=%0b", i, S, Cout);
      end

      // First result after release: FFFF + 0001 + 1 = 1_0001.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
      check("reset_release", {Cout, S}, 17'h10001);
      $display("release: S=%04h Cout=%0b", S, Cout);

      // Directed vectors, back to back. Each result must appear one edge
      // after its operands are sampled.
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         A   = vecs[i].a;
         B   = vecs[i].b;
         Cin = vecs[i].cin;
         @(posedge clk);
         #2;
         check($sformatf("vec%0d", i), {Cout, S}, {vecs[i].cout, vecs[i].s});
         $display("vec %0d: %04h + %04h + %0b -> S=%04h Cout=%0b",
                  i, vecs[i].a, vecs[i].b, vecs[i].cin, S, Cout);
      end

      // Random operands, changing every cycle, with occasional reset pulses.
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         A     = 16'($urandom);
         B     = 16'($urandom);
         Cin   = 1'($urandom);
         rst_n = ($urandom_range(0, 39) != 0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #3;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
